// File: rtl/rv32i_pkg.sv
// RV32I opcode, field-slice and fusion-state definitions shared by the
// decode-side fusion logic.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI    = 3'b000;

    localparam int OPC_LSB   = 0;
    localparam int OPC_MSB   = 6;
    localparam int RD_LSB    = 7;
    localparam int RD_MSB    = 11;
    localparam int F3_LSB    = 12;
    localparam int F3_MSB    = 14;
    localparam int RS1_LSB   = 15;
    localparam int RS1_MSB   = 19;
    localparam int IMM_I_LSB = 20;
    localparam int IMM_I_MSB = 31;
    localparam int IMM_U_LSB = 12;

    typedef enum logic [0:0] {
        FS_IDLE = 1'b0,
        FS_WAIT = 1'b1
    } fuse_state_e;

    function automatic logic [6:0] instr_opc(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] instr_rs1(input logic [31:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [2:0] instr_f3(input logic [31:0] instr);
        return instr[F3_MSB:F3_LSB];
    endfunction

    // A LUI writing x0 is architecturally a no-op and never starts a pair.
    function automatic logic is_fusable_lui(input logic [31:0] instr);
        return (instr_opc(instr) == OPC_LUI) && (instr_rd(instr) != 5'd0);
    endfunction

    function automatic logic is_addi_self(input logic [31:0] instr, input logic [4:0] rd);
        return (instr_opc(instr) == OPC_OP_IMM) && (instr_f3(instr) == F3_ADDI) &&
               (instr_rd(instr) == rd) && (instr_rs1(instr) == rd);
    endfunction

    function automatic logic [31:0] sext_imm_i(input logic [31:0] instr);
        return {{20{instr[IMM_I_MSB]}}, instr[IMM_I_MSB:IMM_I_LSB]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:IMM_U_LSB], 12'b0};
    endfunction

endpackage

// File: rtl/fusion_pair_detect.sv
// Combinational LUI rd / ADDI rd,rd,imm pair detector producing the full
// 32-bit constant of the fused macro-op.
module fusion_pair_detect
    import rv32i_pkg::*;
(
    input  logic [31:0] head_instr,
    input  logic [31:0] next_instr,
    output logic        fuse,
    output logic [31:0] fused_imm
);

    logic [4:0] w_head_rd;

    // Pair match and constant; the sum wraps modulo 2^32 by construction.
    always_comb begin
        w_head_rd = instr_rd(head_instr);
        fuse      = is_fusable_lui(head_instr) && is_addi_self(next_instr, w_head_rd);
        fused_imm = imm_u(head_instr) + sext_imm_i(next_instr);
    end

endmodule

// File: rtl/fusion_prebuffer.sv
// Instruction pre-buffer between IF/ID and decode: circular FIFO of
// {instr, pc} that fuses a head LUI with a following matching ADDI.
module fusion_prebuffer
    import rv32i_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int FUSE_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fused,
    output logic [31:0] out_imm
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = (FUSE_WAIT > 0) ? $clog2(FUSE_WAIT + 1) : 1;
    localparam bit WAIT_EN = (FUSE_WAIT > 0);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((FUSE_WAIT > 0) ? FUSE_WAIT - 1 : 0);

    logic [31:0]    r_mem_instr [DEPTH];
    logic [31:0]    r_mem_pc    [DEPTH];
    logic [AW-1:0]  r_rptr;
    logic [AW-1:0]  r_wptr;
    logic [CW-1:0]  r_count;
    fuse_state_e    r_state;
    logic [WCW-1:0] r_wait_cnt;

    logic [AW-1:0]  w_rptr_p1;
    logic [31:0]    w_head_instr;
    logic [31:0]    w_head_pc;
    logic [31:0]    w_next_instr;
    logic           w_pair_fuse;
    logic [31:0]    w_pair_imm;
    logic           w_valid;
    logic           w_fused;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_popcnt;
    logic [CW-1:0]  w_count_nxt;
    logic [AW-1:0]  w_nh_idx;
    logic [31:0]    w_nh_instr;
    logic           w_enter_wait;

    fusion_pair_detect u_pair_detect (
        .head_instr (w_head_instr),
        .next_instr (w_next_instr),
        .fuse       (w_pair_fuse),
        .fused_imm  (w_pair_imm)
    );

    // Head/next views of the FIFO and the handshake bookkeeping.
    always_comb begin
        w_rptr_p1    = r_rptr + AW'(1);
        w_head_instr = r_mem_instr[r_rptr];
        w_head_pc    = r_mem_pc[r_rptr];
        w_next_instr = r_mem_instr[w_rptr_p1];

        in_ready = (r_count < CW'(DEPTH)) && !flush;
        w_valid  = (r_state == FS_IDLE) && (r_count != CW'(0));
        w_fused  = w_valid && (r_count >= CW'(2)) && w_pair_fuse;
        w_push   = in_valid && in_ready;
        w_pop    = w_valid && out_ready;

        if (!w_pop) begin
            w_popcnt = CW'(0);
        end else if (w_fused) begin
            w_popcnt = CW'(2);
        end else begin
            w_popcnt = CW'(1);
        end
        w_count_nxt = r_count + CW'(w_push) - w_popcnt;
    end

    // Look ahead to the head seen after this edge: a lone fusable LUI that
    // becomes the new head starts waiting from the very next cycle.
    always_comb begin
        w_nh_idx = r_rptr + w_popcnt[AW-1:0];
        if (r_count == w_popcnt) begin
            w_nh_instr = in_instr;
        end else begin
            w_nh_instr = r_mem_instr[w_nh_idx];
        end
        w_enter_wait = WAIT_EN && (w_count_nxt == CW'(1)) &&
                       ((r_count == CW'(0)) || w_pop) && is_fusable_lui(w_nh_instr);
    end

    // Output gating: payload reads as zero whenever nothing is offered.
    always_comb begin
        out_valid = w_valid;
        out_fused = w_fused;
        if (w_valid) begin
            out_instr = w_head_instr;
            out_pc    = w_head_pc;
        end else begin
            out_instr = 32'd0;
            out_pc    = 32'd0;
        end
        if (w_fused) begin
            out_imm = w_pair_imm;
        end else begin
            out_imm = 32'd0;
        end
    end

    // Storage is deliberately left out of reset; validity comes from r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= in_instr;
            r_mem_pc[r_wptr]    <= in_pc;
        end
    end

    // Pointers, occupancy and the LUI wait FSM; flush outranks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_state    <= FS_IDLE;
            r_wait_cnt <= '0;
        end else if (flush) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_state    <= FS_IDLE;
            r_wait_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr  <= r_rptr + w_popcnt[AW-1:0];
            r_count <= w_count_nxt;
            case (r_state)
                FS_IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_enter_wait) begin
                        r_state <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    // A successor ends the wait; otherwise give up after FUSE_WAIT cycles.
                    if (w_push || (r_wait_cnt == WAIT_LAST)) begin
                        r_state    <= FS_IDLE;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                default: begin
                    r_state    <= FS_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fusion_prebuffer.sv
// Directed self-checking bench for fusion_prebuffer (DEPTH=4, FUSE_WAIT=2).
module tb_fusion_prebuffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fused;
    logic [31:0] out_imm;

    int checks;
    int errors;

    localparam logic [31:0] LUI5      = 32'h123452B7;  // lui  x5, 0x12345
    localparam logic [31:0] LUI7      = 32'h123453B7;  // lui  x7, 0x12345
    localparam logic [31:0] ADDI5_678 = 32'h67828293;  // addi x5, x5, 0x678
    localparam logic [31:0] ADDI5_FFF = 32'hFFF28293;  // addi x5, x5, -1
    localparam logic [31:0] ADDI5_1   = 32'h00128293;  // addi x5, x5, 1
    localparam logic [31:0] ADDI6_1   = 32'h00128313;  // addi x6, x5, 1
    localparam logic [31:0] ADDI7_2   = 32'h00238393;  // addi x7, x7, 2

    fusion_prebuffer #(.DEPTH(4), .FUSE_WAIT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_fused (out_fused),
        .out_imm   (out_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [98:0] obs;
    logic [98:0] exp_v;
    assign obs = {in_ready, out_valid, out_fused, out_instr, out_pc, out_imm};

    function automatic logic [98:0] pack(input logic rdy, input logic v, input logic f,
                                         input logic [31:0] i, input logic [31:0] p,
                                         input logic [31:0] m);
        return {rdy, v, f, i, p, m};
    endfunction

    // addi x1, x0, k : a plain, never-fusing filler word
    function automatic logic [31:0] filler(input int k);
        return 32'h00000093 | (32'(k) << 20);
    endfunction

    task automatic drv(input logic v, input logic [31:0] i, input logic [31:0] p, input logic r);
        in_valid  = v;
        in_instr  = i;
        in_pc     = p;
        out_ready = r;
    endtask

    task automatic test_reset();
        #3;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_during: got %h expected %h", obs, exp_v); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_after: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_fuse(input logic [31:0] addi, input logic [31:0] pc0,
                             input logic [31:0] imm_exp);
        @(negedge clk); drv(1'b1, LUI5, pc0, 1'b1); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fuse_empty: got %h expected %h", obs, exp_v); end
        @(negedge clk); drv(1'b1, addi, pc0 + 32'd4, 1'b1); #1;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fuse_wait: got %h expected %h", obs, exp_v); end
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 1'b1); #1;
        exp_v = pack(1'b1, 1'b1, 1'b1, LUI5, pc0, imm_exp);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fuse_out: got %h expected %h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fuse_drained: got %h expected %h", obs, exp_v); end
        checks++;
        if (dut.r_count !== 3'd0) begin errors++; $display("FAIL fuse_count: got %0d expected 0", dut.r_count); end
    endtask

    task automatic test_no_fuse();
        @(negedge clk); drv(1'b1, LUI5, 32'h200, 1'b1);
        @(negedge clk); drv(1'b1, ADDI6_1, 32'h204, 1'b1);
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 1'b1); #1;
        exp_v = pack(1'b1, 1'b1, 1'b0, LUI5, 32'h200, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL nofuse_first: got %h expected %h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = pack(1'b1, 1'b1, 1'b0, ADDI6_1, 32'h204, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL nofuse_second: got %h expected %h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL nofuse_empty: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_lone_lui();
        @(negedge clk); drv(1'b1, LUI5, 32'h300, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); drv(1'b0, 32'h0, 32'h0, 1'b1); #1;
            exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL lone_stall%0d: got %h expected %h", c, obs, exp_v); end
        end
        @(negedge clk); #1;
        exp_v = pack(1'b1, 1'b1, 1'b0, LUI5, 32'h300, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lone_issue: got %h expected %h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL lone_empty: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_wait_fuse();
        @(negedge clk); drv(1'b1, LUI5, 32'h400, 1'b1);
        @(negedge clk); drv(1'b1, ADDI5_1, 32'h404, 1'b1); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL waitfuse_stall: got %h expected %h", obs, exp_v); end
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 1'b1); #1;
        exp_v = pack(1'b1, 1'b1, 1'b1, LUI5, 32'h400, 32'h12345001);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL waitfuse_out: got %h expected %h", obs, exp_v); end
        @(negedge clk); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL waitfuse_empty: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drv(1'b1, filler(k), 32'h500 + 32'(4 * k), 1'b0);
        end
        @(negedge clk); drv(1'b1, filler(4), 32'h510, 1'b0); #1;
        exp_v = pack(1'b0, 1'b1, 1'b0, filler(0), 32'h500, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL full_reject: got %h expected %h", obs, exp_v); end
        @(negedge clk); drv(1'b1, filler(4), 32'h510, 1'b1); #1;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL full_pop0: got %h expected %h", obs, exp_v); end
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) drv(1'b1, filler(4), 32'h510, 1'b1);
            else if (k == 2) drv(1'b1, filler(5), 32'h514, 1'b1);
            else drv(1'b0, 32'h0, 32'h0, 1'b1);
            #1;
            exp_v = pack(1'b1, 1'b1, 1'b0, filler(k), 32'h500 + 32'(4 * k), 32'h0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL wrap_order%0d: got %h expected %h", k, obs, exp_v); end
        end
        @(negedge clk); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_empty: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_flush_in_wait();
        @(negedge clk); drv(1'b1, LUI7, 32'h600, 1'b1);
        @(negedge clk); drv(1'b1, ADDI7_2, 32'h604, 1'b1); flush = 1'b1; #1;
        exp_v = pack(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL flush_ready: got %h expected %h", obs, exp_v); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); flush = 1'b0; drv(1'b0, 32'h0, 32'h0, 1'b1); #1;
            exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL flush_empty%0d: got %h expected %h", c, obs, exp_v); end
        end
        checks++;
        if (dut.r_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", dut.r_count); end
        @(negedge clk); drv(1'b1, filler(9), 32'h700, 1'b1);
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 1'b1); #1;
        exp_v = pack(1'b1, 1'b1, 1'b0, filler(9), 32'h700, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL flush_refill: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk); drv(1'b1, filler(1), 32'h800, 1'b0);
        @(negedge clk); drv(1'b1, LUI5, 32'h804, 1'b0);
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 1'b0); #1;
        exp_v = pack(1'b1, 1'b1, 1'b0, filler(1), 32'h800, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_before: got %h expected %h", obs, exp_v); end
        rst_n = 1'b0; #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_async: got %h expected %h", obs, exp_v); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_after: got %h expected %h", obs, exp_v); end
        @(negedge clk); drv(1'b1, filler(2), 32'h900, 1'b1);
        @(negedge clk); drv(1'b0, 32'h0, 32'h0, 1'b1); #1;
        exp_v = pack(1'b1, 1'b1, 1'b0, filler(2), 32'h900, 32'h0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL midrst_refill: got %h expected %h", obs, exp_v); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        flush  = 1'b0;
        drv(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_fuse(ADDI5_678, 32'h100, 32'h12345678);
        test_fuse(ADDI5_FFF, 32'h140, 32'h12344FFF);
        test_no_fuse();
        test_lone_lui();
        test_wait_fuse();
        test_full_wrap();
        test_flush_in_wait();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
